// File: rtl/mux_scan_pkg.sv
// Shared sizes, FSM state encoding and a lowest-set-bit helper for the
// 16-channel byte mux scanner.
package mux_scan_pkg;

  localparam int NUM_CH = 16;
  localparam int CH_W   = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } state_t;

  // Index of the lowest enabled channel; 0 when the mask is empty.
  function automatic logic [CH_W-1:0] first_set(input logic [NUM_CH-1:0] mask);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Output beat stream of the scanner. A beat transfers on every rising clk edge
// where tx_valid && tx_ready; once tx_valid is high, tx_data/tx_ch/tx_sof/tx_eof
// stay stable and tx_valid stays high until that transfer happens.
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic [DATA_W-1:0] tx_data;
  logic [CH_W-1:0]   tx_ch;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_sof;
  logic              tx_eof;

  modport master (
    output tx_data, tx_ch, tx_valid, tx_sof, tx_eof,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_ch, tx_valid, tx_sof, tx_eof,
    output tx_ready
  );

endinterface

// File: rtl/mux_scan_ctrl_next_ch_find.sv
// Finds the next enabled channel above the current index; last is set when
// no higher channel is enabled (next_idx then just echoes idx).
module next_ch_find
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   idx,
  output logic [CH_W-1:0]   next_idx,
  output logic              last
);

  always_comb begin
    next_idx = idx;
    last     = 1'b1;
    // Scan downwards so the lowest qualifying index is the one that sticks.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(idx))) begin
        next_idx = CH_W'(i);
        last     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled channels of an external 16:1 byte mux: drives sel, waits
// for the mux to settle, captures mux_y and emits one beat per enabled channel.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 2  // legal 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [CH_W-1:0]   sel,
  input  logic [DATA_W-1:0] mux_y,
  output logic              busy,
  output logic              frame_done,
  output state_t            state_dbg,
  mux_scan_ctrl_if.master   tx
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);

  state_t            state, state_n;
  logic [NUM_CH-1:0] mask_q, mask_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CH_W-1:0]   sel_q, sel_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [CH_W-1:0]   ch_q, ch_n;
  logic              valid_q, valid_n;
  logic              sof_q, sof_n;
  logic              eof_q, eof_n;
  logic              first_q, first_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;

  logic [CH_W-1:0]   next_idx;
  logic              is_last;

  next_ch_find u_next (
    .mask     (mask_q),
    .idx      (sel_q),
    .next_idx (next_idx),
    .last     (is_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mask_q  <= '0;
      cnt     <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      mask_q  <= mask_n;
      cnt     <= cnt_n;
      sel_q   <= sel_n;
      data_q  <= data_n;
      ch_q    <= ch_n;
      valid_q <= valid_n;
      sof_q   <= sof_n;
      eof_q   <= eof_n;
      first_q <= first_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    mask_n  = mask_q;
    cnt_n   = cnt;
    sel_n   = sel_q;
    data_n  = data_q;
    ch_n    = ch_q;
    valid_n = valid_q;
    sof_n   = sof_q;
    eof_n   = eof_q;
    first_n = first_q;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          mask_n = ch_mask;
          // An empty mask completes immediately with no beats.
          if (ch_mask == '0) begin
            done_n = 1'b1;
          end else begin
            sel_n   = first_set(ch_mask);
            cnt_n   = SETTLE_LOAD;
            first_n = 1'b1;
            state_n = SETTLE;
          end
        end
      end

      SETTLE: begin
        cnt_n = cnt - 1'b1;
        if (cnt <= 1) state_n = CAPTURE;
      end

      CAPTURE: begin
        data_n  = mux_y;
        ch_n    = sel_q;
        valid_n = 1'b1;
        sof_n   = first_q;
        eof_n   = is_last;
        state_n = SEND;
      end

      SEND: begin
        if (valid_q && tx.tx_ready) begin
          valid_n = 1'b0;
          sof_n   = 1'b0;
          eof_n   = 1'b0;
          first_n = 1'b0;
          if (!eof_q) begin
            sel_n   = next_idx;
            cnt_n   = SETTLE_LOAD;
            state_n = SETTLE;
          end else begin
            done_n  = 1'b1;
            state_n = IDLE;
            // Back-to-back frames relatch the mask in the same edge.
            if (continuous) begin
              mask_n = ch_mask;
              if (ch_mask != '0) begin
                sel_n   = first_set(ch_mask);
                cnt_n   = SETTLE_LOAD;
                first_n = 1'b1;
                state_n = SETTLE;
              end
            end
          end
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  assign sel         = sel_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign state_dbg   = state;
  assign tx.tx_data  = data_q;
  assign tx.tx_ch    = ch_q;
  assign tx.tx_valid = valid_q;
  assign tx.tx_sof   = sof_q;
  assign tx.tx_eof   = eof_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed-plus-random bench for mux_scan_ctrl: a frame-level model builds the
// expected beat list from the mask and checks beats, latency, busy and frame_done.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  localparam int S  = 2;
  localparam int BW = 2 + CH_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              continuous = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic [CH_W-1:0]   sel;
  logic [DATA_W-1:0] mux_y;
  logic              busy;
  logic              frame_done;
  state_t            state_dbg;

  logic [DATA_W-1:0] tab [NUM_CH];
  logic [BW-1:0]     exp_q[$];
  int                checks = 0;
  int                failures = 0;

  mux_scan_ctrl_if tx_if ();

  mux_scan_ctrl #(.SETTLE_CYC(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .ch_mask    (ch_mask),
    .sel        (sel),
    .mux_y      (mux_y),
    .busy       (busy),
    .frame_done (frame_done),
    .state_dbg  (state_dbg),
    .tx         (tx_if.master)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Behavioural 16:1 mux
  assign mux_y = tab[sel];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] cur_beat();
    return {tx_if.tx_sof, tx_if.tx_eof, tx_if.tx_ch, tx_if.tx_data};
  endfunction

  // Expected beats of one frame: enabled channels ascending, SOF on lowest, EOF on highest.
  task automatic push_frame(input logic [NUM_CH-1:0] mask);
    int lo = -1;
    int hi = -1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) begin
        if (lo < 0) lo = i;
        hi = i;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) exp_q.push_back({(i == lo), (i == hi), CH_W'(i), tab[i]});
    end
  endtask

  // Driver + scoreboard for one scan. ready_mode: 0 always, 1 random, 2 low for `hold` cycles.
  // drop_at > 0: after that many accepted beats, drop continuous and pulse start with a new mask.
  task automatic run_frame(input logic [NUM_CH-1:0] mask, input int ready_mode, input int hold,
                           input logic cont, input int nframes, input int drop_at);
    int gap = 0;
    int beats = 0;
    int dones = 0;
    int lo_cnt = 0;
    int tail = -1;
    int last_idx = -1;
    int done_due;
    logic prev_valid = 1'b0;
    logic exp_busy;
    logic finished = 1'b0;
    logic r;
    logic [BW-1:0] prev_beat = '0;
    logic [BW-1:0] got;
    logic [BW-1:0] exp;

    exp_q.delete();
    for (int f = 0; f < nframes; f++) push_frame(mask);
    for (int i = 0; i < NUM_CH; i++) if (mask[i]) last_idx = i;

    @(negedge clk);
    ch_mask = mask;
    continuous = cont;
    start = 1'b1;
    tx_if.tx_ready = 1'b0;
    exp_busy = (mask != '0);
    done_due = (mask == '0) ? 1 : -1;

    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      gap++;
      got = cur_beat();
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("frame_done", 32'(frame_done), 32'(gap == done_due));
      if (frame_done) dones++;
      if (busy) chk("sel_enabled", 32'(mask[sel]), 32'd1);
      if (tx_if.tx_valid && !prev_valid) chk("latency", 32'(gap), 32'(S + 2));
      if (tx_if.tx_valid && prev_valid) chk("hold_stable", 32'(got), 32'(prev_beat));
      if (tail >= 0) begin
        chk("idle_valid", 32'(tx_if.tx_valid), 32'd0);
        if (mask != '0) chk("sel_hold", 32'(sel), 32'(last_idx));
        tail--;
        if (tail == 0) finished = 1'b1;
      end
      if (frame_done && dones == nframes) tail = 4;

      case (ready_mode)
        0: r = 1'b1;
        1: r = 1'($urandom_range(0, 1));
        default: begin
          r = (lo_cnt >= hold);
          if (tx_if.tx_valid) lo_cnt++;
        end
      endcase
      tx_if.tx_ready = r;

      if (tx_if.tx_valid && r) begin
        chk("beat_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          chk("beat", 32'(got), 32'(exp));
          done_due = exp[BW-2] ? 1 : -1;
          if (exp[BW-2]) exp_busy = continuous && (ch_mask != '0);
        end
        beats++;
        gap = 0;
        if (beats == drop_at) begin
          continuous = 1'b0;
          start = 1'b1;
          ch_mask = NUM_CH'($urandom);
        end
      end
      prev_valid = tx_if.tx_valid;
      prev_beat = got;
    end

    chk("frame_end", 32'(finished), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(dones), 32'(nframes));
    tx_if.tx_ready = 1'b0;
    continuous = 1'b0;
  endtask

  initial begin
    logic [NUM_CH-1:0] m;
    logic found;
    int pc;

    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) tab[i] = 8'hA0 + 8'(i);

    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("rst_data", 32'(tx_if.tx_data), 32'd0);
    chk("rst_ch", 32'(tx_if.tx_ch), 32'd0);
    chk("rst_sofeof", 32'({tx_if.tx_sof, tx_if.tx_eof}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full mask, data A0..AF
    run_frame(16'hFFFF, 0, 0, 1'b0, 1, 0);

    for (int i = 0; i < NUM_CH; i++) tab[i] = 8'($urandom);

    // Sparse mask, random backpressure
    run_frame(16'h8421, 1, 0, 1'b0, 1, 0);

    // Single channel, ready held low 20 cycles
    run_frame(16'h0010, 2, 20, 1'b0, 1, 0);

    // Empty mask
    run_frame(16'h0000, 0, 0, 1'b0, 1, 0);

    // Random masks with random backpressure
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NUM_CH; i++) tab[i] = 8'($urandom);
      m = NUM_CH'($urandom);
      run_frame(m, 1, 0, 1'b0, 1, 0);
    end

    // Continuous + start mid-frame, continuous dropped after first beat: one frame
    m = NUM_CH'($urandom) | 16'h0101;
    run_frame(m, 1, 0, 1'b1, 1, 1);

    // Continuous for two frames, dropped at first beat of the second
    m = NUM_CH'($urandom) | 16'h2040;
    pc = $countones(m);
    run_frame(m, 0, 0, 1'b1, 2, pc + 1);

    // Reset during the second beat's SEND in continuous mode
    @(negedge clk);
    ch_mask = 16'h0003;
    continuous = 1'b1;
    start = 1'b1;
    tx_if.tx_ready = 1'b1;
    found = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      chk("pre_rst_done", 32'(frame_done), 32'd0);
      if (tx_if.tx_valid && tx_if.tx_ch == 4'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk("second_beat_seen", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    continuous = 1'b0;
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("mid_rst_data", 32'(tx_if.tx_data), 32'd0);
    chk("mid_rst_ch", 32'(tx_if.tx_ch), 32'd0);
    chk("mid_rst_sofeof", 32'({tx_if.tx_sof, tx_if.tx_eof}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(frame_done), 32'd0);
    chk("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(tx_if.tx_valid), 32'd0);
      chk("post_rst_done", 32'(frame_done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
